// File: rtl/exception_sequencer.sv
// Exception/interrupt sequencer for the ID stage: takes illegal-instruction and
// interrupt traps from user mode, returns via eret, and flags faults in kernel mode.
module exception_sequencer #(
    parameter logic [31:0] INT_VECTOR = 32'h80000004,
    parameter logic [31:0] EXC_VECTOR = 32'h80000008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic        id_legit,
    input  logic        id_eret,
    input  logic [31:0] id_pc,
    input  logic        irq,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic        epc_we,
    output logic        kernel_mode,
    output logic        irq_ack,
    output logic        double_fault
);

    typedef enum logic [1:0] {
        USER   = 2'd0,
        TRAP   = 2'd1,
        KERNEL = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] vector, vector_next;
    logic [31:0] epc_next;
    logic        trap_irq, trap_irq_next;
    logic        double_fault_next;
    logic        irq_prev, irq_pending;
    logic        issue;

    assign issue = id_valid & ~id_stall;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= KERNEL;
            epc          <= 32'd0;
            vector       <= 32'd0;
            trap_irq     <= 1'b0;
            double_fault <= 1'b0;
            irq_prev     <= 1'b0;
            irq_pending  <= 1'b0;
        end else begin
            state        <= state_next;
            epc          <= epc_next;
            vector       <= vector_next;
            trap_irq     <= trap_irq_next;
            double_fault <= double_fault_next;
            irq_prev     <= irq;
            // A fresh rising edge wins over the acknowledge of the previous one.
            irq_pending  <= (irq & ~irq_prev) | (irq_pending & ~irq_ack);
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no latches.
    always_comb begin
        state_next        = state;
        epc_next          = epc;
        vector_next       = vector;
        trap_irq_next     = trap_irq;
        double_fault_next = double_fault;
        flush             = 1'b0;
        redirect          = 1'b0;
        redirect_pc       = 32'd0;
        epc_we            = 1'b0;
        kernel_mode       = 1'b0;
        irq_ack           = 1'b0;

        case (state)
            USER: begin
                if (issue) begin
                    // Illegal/eret outranks the interrupt, which stays pending.
                    if (!id_legit || id_eret) begin
                        state_next    = TRAP;
                        epc_next      = id_pc + 32'd4;
                        vector_next   = EXC_VECTOR;
                        trap_irq_next = 1'b0;
                    end else if (irq_pending) begin
                        state_next    = TRAP;
                        epc_next      = id_pc;
                        vector_next   = INT_VECTOR;
                        trap_irq_next = 1'b1;
                    end
                end
            end
            TRAP: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = vector;
                epc_we      = 1'b1;
                kernel_mode = 1'b1;
                irq_ack     = trap_irq;
                state_next  = KERNEL;
            end
            KERNEL: begin
                kernel_mode = 1'b1;
                if (issue) begin
                    if (id_eret)
                        state_next = RETURN;
                    else if (!id_legit)
                        double_fault_next = 1'b1;
                end
            end
            RETURN: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = epc;
                state_next  = USER;
            end
            default: state_next = KERNEL;
        endcase
    end

endmodule
